// File: rtl/pq_div_pkg.sv
// ============================================================================
// pq_div_pkg : shared types and sizing helpers for the sequential divider
// Rev 1.0    : DIV_SIGNED_EN adds the FIX state for two's-complement operation
// ============================================================================
`default_nettype none

package pq_div_pkg;

  localparam int DEFAULT_WIDTH = 56;

`ifdef DIV_SIGNED_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2,
    ST_FIX  = 2'd3
  } div_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;
`endif

  // Counter must be able to hold WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pq_div_step.sv
// ============================================================================
// pq_div_step : one combinational restoring-division iteration on {P, A}
// Rev 1.0
// ============================================================================
`default_nettype none

module pq_div_step
  import pq_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   p_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH:0]   p_out,
  output logic [WIDTH-1:0] a_out,
  output logic             q_bit
);

  logic [WIDTH:0] p_shift;
  logic [WIDTH:0] p_diff;
  logic           unused_p_msb;

  // P stays below D, so its top bit is always clear before the shift.
  assign unused_p_msb = p_in[WIDTH];

  always_comb begin
    p_shift = {p_in[WIDTH-1:0], a_in[WIDTH-1]};
    p_diff  = p_shift - {1'b0, d_in};
    q_bit   = ~p_diff[WIDTH];
    p_out   = q_bit ? p_diff : p_shift;
    a_out   = {a_in[WIDTH-2:0], q_bit};
  end

endmodule

`default_nettype wire

// File: rtl/pq_seq_divider.sv
// ============================================================================
// pq_seq_divider : iterative restoring divider, one quotient bit per clock
// Rev 1.0        : define DIV_SIGNED_EN for truncating two's-complement mode
// ============================================================================
`default_nettype none

module pq_seq_divider
  import pq_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int               CNT_W     = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
`ifdef DIV_SIGNED_EN
  logic             rem_neg_q, rem_neg_d;
  logic             quot_neg_q, quot_neg_d;
`endif

  logic [WIDTH:0]   step_p;
  logic [WIDTH-1:0] step_a;
  logic             unused_qbit;

  pq_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .p_in  (p_q),
    .a_in  (a_q),
    .d_in  (d_q),
    .p_out (step_p),
    .a_out (step_a),
    .q_bit (unused_qbit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      p_q        <= '0;
      a_q        <= '0;
      d_q        <= '0;
      cnt_q      <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      dbz_q      <= 1'b0;
`ifdef DIV_SIGNED_EN
      rem_neg_q  <= 1'b0;
      quot_neg_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      a_q        <= a_d;
      d_q        <= d_d;
      cnt_q      <= cnt_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dbz_q      <= dbz_d;
`ifdef DIV_SIGNED_EN
      rem_neg_q  <= rem_neg_d;
      quot_neg_q <= quot_neg_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    a_d        = a_q;
    d_d        = d_q;
    cnt_d      = cnt_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dbz_d      = dbz_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
`ifdef DIV_SIGNED_EN
    rem_neg_d  = rem_neg_q;
    quot_neg_d = quot_neg_q;
`endif

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          p_d   = '0;
          cnt_d = '0;
`ifdef DIV_SIGNED_EN
          // Iterate on magnitudes; the most-negative value maps onto itself,
          // which is its correct unsigned magnitude.
          a_d        = dividend[WIDTH-1] ? -dividend : dividend;
          d_d        = divisor[WIDTH-1]  ? -divisor  : divisor;
          rem_neg_d  = dividend[WIDTH-1];
          quot_neg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
`else
          a_d = dividend;
          d_d = divisor;
`endif
          if (divisor == '0) begin
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_CALC;
          end
        end
      end

      ST_CALC: begin
        p_d   = step_p;
        a_d   = step_a;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
`ifdef DIV_SIGNED_EN
          state_d = ST_FIX;
`else
          // Load results straight from the final iteration so DONE is entered
          // with stable outputs.
          quot_d  = step_a;
          rem_d   = step_p[WIDTH-1:0];
          dbz_d   = 1'b0;
          state_d = ST_DONE;
`endif
        end
      end

`ifdef DIV_SIGNED_EN
      ST_FIX: begin
        quot_d  = quot_neg_q ? -a_q : a_q;
        rem_d   = rem_neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
        dbz_d   = 1'b0;
        state_d = ST_DONE;
      end
`endif

      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_pq_seq_divider.sv
// ============================================================================
// tb_pq_seq_divider : vector table, random model comparison and corner sequences
// Rev 1.0           : follows DIV_SIGNED_EN for the signed build
// ============================================================================
`default_nettype none

module tb_pq_seq_divider;

  localparam int W     = 56;
  localparam int BOUND = 200;
`ifdef DIV_SIGNED_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif

  typedef struct {
    logic [W-1:0] n;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks   = 0;
  int failures = 0;

  pq_seq_divider #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Division by the arithmetic rules, independent of any iteration detail.
  task automatic model(input logic [W-1:0] n, input logic [W-1:0] d,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    if (d == '0) begin
      q = '1;
      r = n;
      z = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      longint sn;
      longint sd;
      sn = longint'($signed(n));
      sd = longint'($signed(d));
      q  = W'(sn / sd);
      r  = W'(sn % sd);
`else
      q = n / d;
      r = n % d;
`endif
      z = 1'b0;
    end
  endtask

  // Called at the first falling edge after the accept edge.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < BOUND) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      chk("result_timeout", 64'(lat), 64'(BOUND - 1));
      lat = -1;
    end
  endtask

  task automatic handshake;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [W-1:0] n, input logic [W-1:0] d,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                        input int elat);
    int lat;
    int guard = 0;
    while (!in_ready && guard < BOUND) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1;
    dividend = n;
    divisor  = d;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    dividend = W'({$urandom, $urandom});
    divisor  = W'({$urandom, $urandom});
    wait_result(lat);
    chk({name, "_lat"}, 64'(lat), 64'(elat));
    chk({name, "_q"}, 64'(quotient), 64'(eq));
    chk({name, "_r"}, 64'(remainder), 64'(er));
    chk({name, "_dbz"}, 64'(div_by_zero), 64'(ez));
    handshake();
    chk({name, "_idle_valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    vec_t         vecs[8];
    logic [W-1:0] mq, mr, hq, hr;
    logic         mz;
    logic [W-1:0] rn, rd;
    int           lat;
    int           stray;
    logic [W-1:0] most_neg;

    most_neg = {1'b1, {(W-1){1'b0}}};
    vecs[0] = '{W'(1000), W'(26), W'(38), W'(12), 1'b0, LAT};
    vecs[1] = '{W'(123), W'(0), {W{1'b1}}, W'(123), 1'b1, 1};
    vecs[2] = '{W'(5), W'(9), W'(0), W'(5), 1'b0, LAT};
    vecs[3] = '{W'(100), W'(7), W'(14), W'(2), 1'b0, LAT};
    vecs[4] = '{W'(0), W'(5), W'(0), W'(0), 1'b0, LAT};
`ifdef DIV_SIGNED_EN
    vecs[5] = '{-W'(7), W'(2), -W'(3), -W'(1), 1'b0, LAT};
    vecs[6] = '{W'(7), -W'(2), -W'(3), W'(1), 1'b0, LAT};
    vecs[7] = '{most_neg, {W{1'b1}}, most_neg, W'(0), 1'b0, LAT};
`else
    vecs[5] = '{{W{1'b1}}, W'(1), {W{1'b1}}, W'(0), 1'b0, LAT};
    vecs[6] = '{{W{1'b1}}, {W{1'b1}}, W'(1), W'(0), 1'b0, LAT};
    vecs[7] = '{most_neg, W'(3), W'(most_neg / 3), W'(most_neg % 3), 1'b0, LAT};
`endif

    repeat (3) @(negedge clk);
    chk("rst_in_valid", 64'(out_valid), 64'd0);
    chk("rst_quot", 64'(quotient), 64'd0);
    chk("rst_rem", 64'(remainder), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].n, vecs[i].d, vecs[i].q, vecs[i].r,
             vecs[i].z, vecs[i].lat);
    end

    for (int i = 0; i < 24; i++) begin
      rn = W'({$urandom, $urandom});
      rd = W'({$urandom, $urandom}) >> $urandom_range(0, W - 1);
      if (i % 8 == 3) rd = '0;
      model(rn, rd, mq, mr, mz);
      run_op($sformatf("rnd%0d", i), rn, rd, mq, mr, mz, (rd == '0) ? 1 : LAT);
    end

    // Backpressure: result held while new operands wait on in_valid.
    in_valid = 1'b1;
    dividend = W'(1000);
    divisor  = W'(26);
    @(posedge clk);
    @(negedge clk);
    dividend = W'(77);
    divisor  = W'(5);
    wait_result(lat);
    chk("bp_lat", 64'(lat), 64'(LAT));
    hq = quotient;
    hr = remainder;
    chk("bp_q", 64'(hq), 64'd38);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_q", 64'(quotient), 64'd38);
      chk("bp_hold_r", 64'(remainder), 64'd12);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_after_valid", 64'(out_valid), 64'd0);
    chk("bp_after_ready", 64'(in_ready), 64'd1);
    chk("bp_after_q", 64'(quotient), 64'(hq));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_second_busy", 64'(in_ready), 64'd0);
    wait_result(lat);
    chk("bp2_lat", 64'(lat), 64'(LAT));
    chk("bp2_q", 64'(quotient), 64'd15);
    chk("bp2_r", 64'(remainder), 64'd2);
    handshake();

    // Reset in the middle of an iteration.
    in_valid = 1'b1;
    dividend = W'(1000);
    divisor  = W'(3);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_q", 64'(quotient), 64'd0);
    chk("mid_rst_r", 64'(remainder), 64'd0);
    chk("mid_rst_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    stray = 0;
    for (int i = 0; i < LAT + 5; i++) begin
      if (out_valid) stray++;
      @(negedge clk);
    end
    chk("mid_rst_no_result", 64'(stray), 64'd0);
    run_op("post_rst", W'(100), W'(7), W'(14), W'(2), 1'b0, LAT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pq_seq_divider.md
# pq_seq_divider

Parametrised, iterative restoring divider producing quotient and remainder of a WIDTH-bit dividend by a run-time WIDTH-bit divisor, one quotient bit per clock. It replaces fixed-constant combinational division in the power-quality datapath (RMS/averaging normalisation) where a full-width combinational array is too costly in area and timing. It uses valid/ready handshakes on both the input and output sides, so it can sit between the accumulator stage and downstream scaling logic.

## Interface
- WIDTH, 56, operand/result width in bits (≥ 2)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands
- dividend  in  WIDTH  numerator
- divisor  in  WIDTH  denominator
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- quotient  out  WIDTH  dividend / divisor
- remainder  out  WIDTH  dividend mod divisor
- div_by_zero  out  1  result produced with divisor == 0

## Operation
- FSM states: IDLE, CALC, DONE (plus FIX when DIV_SIGNED_EN is defined).
- IDLE: in_ready=1. When in_valid&&in_ready, latch operands, clear the (WIDTH+1)-bit partial remainder and the bit counter, and go to CALC. If divisor==0, go straight to DONE instead.
- CALC, per cycle:
  - Shift {P, A} left by 1.
  - Compute P' = P − D at WIDTH+1 bits.
  - If P'[WIDTH]==1, keep P and set the quotient LSB to 0; otherwise P=P' and the LSB is 1.
  - After exactly WIDTH iterations, go to DONE (or FIX).
- DONE: out_valid=1. Outputs stay stable until out_ready; on out_valid&&out_ready, return to IDLE.
- Divide-by-zero result: quotient = all ones, remainder = dividend, div_by_zero=1.
- Otherwise div_by_zero=0, quotient = floor(dividend/divisor), remainder = dividend − quotient·divisor, both unsigned.
- in_ready=0 in every state except IDLE. No new operand is accepted in the same cycle a result is consumed.
- Operand inputs are don't-care except on the accept cycle.
- Reset at any point, including mid-CALC or DONE: state returns to IDLE immediately, the in-flight operation is discarded, and no result is emitted.

## Timing
- Reset values: in_ready=1 (once reset deasserts), out_valid=0, quotient=0, remainder=0, div_by_zero=0.
- Latency from the accept edge to out_valid high: WIDTH+1 cycles unsigned, WIDTH+2 signed. Divide-by-zero takes 1 cycle.
- Throughput: one operation per latency+1 cycles when out_ready is held high.
- Outputs are registered. quotient, remainder and div_by_zero change only on entry to DONE.

## Configuration
- DIV_SIGNED_EN defined: operands are two's complement.
  - At accept, absolute values are latched along with the sign flags.
  - The FIX state (1 cycle) negates the quotient if the operand signs differ, and gives the remainder the dividend's sign (truncating division).
  - Most-negative / −1 yields quotient = most-negative and remainder = 0.
  - Divide by zero yields quotient = all ones (−1) and remainder = dividend.
- DIV_SIGNED_EN undefined: unsigned only. The FIX state and sign logic are absent.

## Structure
- Shared package pq_div_pkg: FSM state enum, default WIDTH constant, and the counter width function ($clog2(WIDTH+1)).
- Sub-module pq_div_step: combinational single restoring iteration. Inputs are P, A and D; outputs are next P, next A and the quotient bit. It is instantiated once inside the FSM.

## Test plan
- Unsigned, WIDTH=56: dividend=1000, divisor=26 → quotient=38, remainder=12, div_by_zero=0, out_valid exactly 57 cycles after accept.
- Divisor 0, dividend=123 → quotient=all ones, remainder=123, div_by_zero=1, out_valid 1 cycle after accept.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid, with in_valid high and new operands → outputs stable, in_ready stays 0, second operation accepted only after the result handshake.
- Edge values: dividend=2^56−1, divisor=1 → quotient=2^56−1, remainder=0. Dividend=5, divisor=9 → quotient=0, remainder=5.
- Reset asserted at CALC cycle 20 → out_valid, quotient, remainder and div_by_zero all 0 immediately; in_ready=1 after release; the next operation 100/7 gives 14 rem 2.
- DIV_SIGNED_EN: −7/2 → −3 rem −1. 7/−2 → −3 rem 1. Most-negative/−1 → most-negative rem 0. Latency 58.
